bv_match_scan: RTL and testbench
================================

// Module: bv_match_scan
// PURPOSE
//  Stage directly upstream of prior_sel in the BV lookup pipeline. Accepts one
//  matched-rule bit vector (bit i set = rule i matched), scans it LANES bits per
//  cycle against a config-written per-rule priority table, and emits the single
//  highest-priority match as a (valid, prior, index) candidate on the sel_* port.
//  The sel_* outputs wire straight to prior_sel's sel_a_* or sel_b_* inputs.
// PARAMETERS
//  BV_WIDTH  64  rule-vector width = number of rules; <=256, multiple of LANES
//  LANES     8   vector bits evaluated per scan cycle; K = BV_WIDTH/LANES
// PORTS
//  clk          in   1         module clock; single clock domain
//  rst_n        in   1         reset, asynchronous assert, active-low
//  bv_in_valid  in   1         bv_in_data is valid
//  bv_in_ready  out  1         block can accept a vector (= state IDLE)
//  bv_in_data   in   BV_WIDTH  matched-rule bit vector
//  cfg_wr_en    in   1         priority-table write strobe
//  cfg_wr_addr  in   8         rule number to write
//  cfg_wr_data  in   8         priority for that rule (larger = higher)
//  sel_valid    out  1         one-cycle pulse: a match was found
//  sel_prior    out  8         priority of winning rule
//  sel_index    out  8         rule number (bit position) of winning rule
//  scan_done    out  1         one-cycle pulse at end of every scan, match or not
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, bv_in_ready=1, sel_valid=0,
//    sel_prior=0, sel_index=0, scan_done=0, chunk ptr=0, all table entries=0.
//  - FSM states: IDLE, SCAN. bv_in_ready = (state==IDLE), combinational from state.
//  - IDLE: on bv_in_valid && bv_in_ready (cycle T) latch bv_in_data, clear
//    running best (found=0), ptr=0, go SCAN. bv_in_valid=0 -> stay IDLE.
//  - SCAN: cycles T+1..T+K; cycle j evaluates bits [j*LANES +: LANES].
//    For each set bit, ascending index, replace running best only if
//    found==0 or table prior > best prior (strict). Ties keep lower index.
//    Priority 0 is a legal priority; a match at prior 0 still reports.
//  - Final chunk (ptr==K-1): at that edge register result, go IDLE, ptr=0.
//    Cycle T+K+1: scan_done=1; sel_valid=found; if found, sel_prior/sel_index
//    = best; if not found, sel_prior/sel_index hold previous values.
//    bv_in_ready=1 in the same cycle, so next accept can be T+K+1.
//  - Fixed latency K+1 cycles accept->result; no early exit on zero chunks.
//    Throughput one vector per K+1 cycles.
//  - sel_valid and scan_done are single-cycle pulses, no backpressure
//    (prior_sel always consumes). Cleared in every cycle not a result cycle.
//  - bv_in_valid while busy: ignored, not latched; upstream must hold
//    valid+data until bv_in_ready.
//  - Priority table: BV_WIDTH x 8 regs, written at clk edge when cfg_wr_en.
//    cfg_wr_addr >= BV_WIDTH ignored. Writes accepted in any state; a chunk
//    uses table contents as of its own evaluation cycle (write at edge E is
//    seen by chunks evaluated after E). No read port.
//  - Index = absolute bit position, zero-extended to 8 bits.
//  - rst_n low mid-scan: scan aborted, no sel_valid/scan_done emitted,
//    table cleared; all outputs to reset values.
// TESTING (BV_WIDTH=64, LANES=8, K=8; T = accept cycle)
//  1 Reset mid-operation -> bv_in_ready=1, sel_valid=0, sel_prior=0,
//    sel_index=0, scan_done=0; table reads as all 0 on next scan.
//  2 prior[5]=0x10; vector bit 5 only -> T+9: sel_valid=1, sel_prior=0x10,
//    sel_index=5, scan_done=1; T+10 both pulses low.
//  3 prior[3]=0x20, prior[60]=0x40; bits 3,60 -> sel_index=60,
//    sel_prior=0x40 (winner in last chunk).
//  4 prior[7]=prior[9]=0x30; bits 7,9 -> sel_index=7 (tie keeps lower index).
//  5 After test 3, vector 0 -> T+9: scan_done=1, sel_valid=0,
//    sel_prior=0x40, sel_index=60 held.
//  6 bv_in_valid held high with two vectors back to back -> second accepted
//    exactly at T+9; rst_n pulsed low at T+4 -> no pulses, outputs 0,
//    bv_in_ready=1 after reset release.

Source files
------------

// File: rtl/bv_match_scan.sv
// bv_match_scan: scans a matched-rule vector LANES bits per cycle and reports the highest-priority match
module bv_match_scan #(
  parameter int BV_WIDTH = 64,
  parameter int LANES    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bv_in_valid,
  output logic                bv_in_ready,
  input  logic [BV_WIDTH-1:0] bv_in_data,
  input  logic                cfg_wr_en,
  input  logic [7:0]          cfg_wr_addr,
  input  logic [7:0]          cfg_wr_data,
  output logic                sel_valid,
  output logic [7:0]          sel_prior,
  output logic [7:0]          sel_index,
  output logic                scan_done
);
  localparam int K  = BV_WIDTH / LANES;
  localparam int AW = BV_WIDTH > 1 ? $clog2(BV_WIDTH) : 1;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t                r_state;
  logic [BV_WIDTH-1:0]   r_vec;
  logic [AW-1:0]         r_ptr;
  logic                  r_found;
  logic [7:0]            r_best_prior;
  logic [7:0]            r_best_index;
  logic                  r_sel_valid;
  logic [7:0]            r_sel_prior;
  logic [7:0]            r_sel_index;
  logic                  r_scan_done;
  logic [7:0]            r_prio [BV_WIDTH];
  logic [AW-1:0]         w_base;
  logic                  w_last;
  logic                  w_found;
  logic [7:0]            w_best_prior;
  logic [7:0]            w_best_index;
  assign bv_in_ready = r_state == IDLE;
  assign sel_valid   = r_sel_valid;
  assign sel_prior   = r_sel_prior;
  assign sel_index   = r_sel_index;
  assign scan_done   = r_scan_done;
  assign w_base      = AW'(r_ptr * LANES);
  assign w_last      = r_ptr == AW'(K - 1);
  // fold the current chunk into the running best; ascending index with strict compare keeps the lower index on ties
  always_comb begin
    w_found      = r_found;
    w_best_prior = r_best_prior;
    w_best_index = r_best_index;
    for (int i = 0; i < LANES; i++) begin
      if (r_vec[w_base + AW'(i)] && (!w_found || r_prio[w_base + AW'(i)] > w_best_prior)) begin
        w_found      = 1'b1;
        w_best_prior = r_prio[w_base + AW'(i)];
        w_best_index = 8'(w_base + AW'(i));
      end
    end
  end
  // priority table; out-of-range rule numbers are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BV_WIDTH; i++) r_prio[i] <= 8'd0;
    end else if (cfg_wr_en && 32'(cfg_wr_addr) < BV_WIDTH) begin
      r_prio[cfg_wr_addr[AW-1:0]] <= cfg_wr_data;
    end
  end
  // accept/scan FSM with registered result pulses; sel_prior/sel_index hold when nothing matched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_ptr        <= '0;
      r_found      <= 1'b0;
      r_best_prior <= 8'd0;
      r_best_index <= 8'd0;
      r_sel_valid  <= 1'b0;
      r_sel_prior  <= 8'd0;
      r_sel_index  <= 8'd0;
      r_scan_done  <= 1'b0;
    end else begin
      r_sel_valid <= 1'b0;
      r_scan_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bv_in_valid) begin
          r_vec   <= bv_in_data;
          r_found <= 1'b0;
          r_ptr   <= '0;
          r_state <= SCAN;
        end
      end else begin
        r_found      <= w_found;
        r_best_prior <= w_best_prior;
        r_best_index <= w_best_index;
        r_ptr        <= w_last ? '0 : r_ptr + AW'(1);
        if (w_last) begin
          r_state     <= IDLE;
          r_scan_done <= 1'b1;
          r_sel_valid <= w_found;
          r_sel_prior <= w_found ? w_best_prior : r_sel_prior;
          r_sel_index <= w_found ? w_best_index : r_sel_index;
        end
      end
    end
  end
endmodule

// File: tb/tb_bv_match_scan.sv
// tb_bv_match_scan: randomized scoreboard bench for bv_match_scan against a max-priority reference model
module tb_bv_match_scan;
  localparam int K = 8;
  typedef struct {
    bit         f;
    logic [7:0] p;
    logic [7:0] i;
    int         due;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bv_in_valid = 1'b0;
  logic        bv_in_ready;
  logic [63:0] bv_in_data = '0;
  logic        cfg_wr_en = 1'b0;
  logic [7:0]  cfg_wr_addr = '0;
  logic [7:0]  cfg_wr_data = '0;
  logic        sel_valid;
  logic [7:0]  sel_prior;
  logic [7:0]  sel_index;
  logic        scan_done;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  tbl [64];
  logic [7:0]  held_p = '0;
  logic [7:0]  held_i = '0;
  exp_t        q[$];

  bv_match_scan #(.BV_WIDTH(64), .LANES(8)) dut (
    .clk(clk), .rst_n(rst_n), .bv_in_valid(bv_in_valid), .bv_in_ready(bv_in_ready),
    .bv_in_data(bv_in_data), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .sel_valid(sel_valid), .sel_prior(sel_prior),
    .sel_index(sel_index), .scan_done(scan_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", n, a, x, cyc);
    end
  endtask

  // winner = highest priority among set bits, lowest index among equals
  function automatic exp_t model(input logic [63:0] v);
    exp_t e;
    int   mx = -1;
    e.f = |v;
    e.p = '0;
    e.i = '0;
    e.due = 0;
    for (int b = 0; b < 64; b++) if (v[b] && int'(tbl[b]) > mx) mx = int'(tbl[b]);
    for (int b = 63; b >= 0; b--) if (v[b] && int'(tbl[b]) == mx) begin
      e.p = tbl[b];
      e.i = 8'(b);
    end
    return e;
  endfunction

  // monitor: result pulses only at the due cycle of the oldest pending scan
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("scan_done", 32'(scan_done), 32'd1);
        chk("sel_valid", 32'(sel_valid), 32'(e.f));
        chk("sel_prior", 32'(sel_prior), 32'(e.p));
        chk("sel_index", 32'(sel_index), 32'(e.i));
      end else begin
        chk("no_pulse", {30'd0, sel_valid, scan_done}, 32'd0);
      end
    end
  end

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    cfg_wr_en = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = d;
    @(posedge clk);
    #1 cfg_wr_en = 1'b0;
    if (a < 8'd64) tbl[a] = d;
  endtask

  task automatic send(input logic [63:0] v, input bit hold, input bit ov, input exp_t oe, output int acc);
    exp_t e;
    bv_in_data = v;
    bv_in_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 100 && acc < 0; n++) begin
      @(negedge clk);
      if (bv_in_ready) acc = cyc;
      @(posedge clk);
    end
    #1 if (!hold) bv_in_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got ready=0 want ready=1");
    end else begin
      e = ov ? oe : model(v);
      e.due = acc + K + 1;
      if (e.f) begin
        held_p = e.p;
        held_i = e.i;
      end else begin
        e.p = held_p;
        e.i = held_i;
      end
      q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d want pending=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    exp_t none;
    exp_t ov;
    int   a1;
    int   a2;
    none = '{f: 1'b0, p: 8'd0, i: 8'd0, due: 0};
    for (int b = 0; b < 64; b++) tbl[b] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bv_in_ready), 32'd1);
    chk("rst_outs", {15'd0, sel_valid, sel_prior, sel_index}, 32'd0);
    chk("rst_done", 32'(scan_done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // single match, then a last-chunk winner, then no-match holding previous result
    cfg_write(8'd5, 8'h10);
    send(64'd1 << 5, 1'b0, 1'b0, none, a1);
    drain();
    cfg_write(8'd3, 8'h20);
    cfg_write(8'd60, 8'h40);
    send((64'd1 << 3) | (64'd1 << 60), 1'b0, 1'b0, none, a1);
    drain();
    send(64'd0, 1'b0, 1'b0, none, a1);
    drain();
    // tie between rules 7 and 9
    cfg_write(8'd7, 8'h30);
    cfg_write(8'd9, 8'h30);
    send((64'd1 << 7) | (64'd1 << 9), 1'b0, 1'b0, none, a1);
    drain();
    // out-of-range write must not alias onto rule 0..15
    cfg_write(8'd64 + 8'd5, 8'hFF);
    send(64'd1 << 5 | 64'd1 << 7, 1'b0, 1'b0, none, a1);
    drain();
    // mid-scan writes: rule 62 rewritten before its chunk, rule 2 after its chunk
    cfg_write(8'd2, 8'd5);
    cfg_write(8'd62, 8'd1);
    ov = '{f: 1'b1, p: 8'd9, i: 8'd62, due: 0};
    send((64'd1 << 2) | (64'd1 << 62), 1'b0, 1'b1, ov, a1);
    cfg_write(8'd62, 8'd9);
    cfg_write(8'd2, 8'hFF);
    drain();
    // back-to-back with valid held high
    send(64'hF0, 1'b1, 1'b0, none, a1);
    send(64'h0F00_0000_0000_0001, 1'b0, 1'b0, none, a2);
    chk("b2b_accept", 32'(a2), 32'(a1 + K + 1));
    drain();
    // random vectors and priorities, including out-of-range addresses and frequent ties
    for (int it = 0; it < 60; it++) begin
      logic [63:0] v;
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        cfg_write(8'($urandom_range(0, 79)), ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
      v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) v = '0;
      send(v, 1'b0, 1'b0, none, a1);
      drain();
    end
    // reset in the middle of a scan aborts it and clears the table
    send(64'hFFFF, 1'b0, 1'b0, none, a1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    for (int b = 0; b < 64; b++) tbl[b] = '0;
    held_p = '0;
    held_i = '0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bv_in_ready), 32'd1);
    chk("mid_rst_outs", {14'd0, sel_valid, scan_done, sel_prior, sel_index}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bv_in_ready), 32'd1);
    @(posedge clk);
    #1;
    send((64'd1 << 9) | (64'd1 << 20), 1'b0, 1'b0, none, a1);
    drain();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
